// File: rtl/vrf_lane_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vrf_lane_seq_pkg
//  Purpose  : Shared definitions for the lane operand sequencer. Holds the
//             default lane geometry, derived address/element widths, the
//             sequencer state enum, the latched instruction-field struct and
//             a helper that clips a requested element count to the lane size.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package vrf_lane_seq_pkg;

    localparam int VRF_DATA_WIDTH = 32;
    localparam int VRF_REG_NUM    = 32;
    localparam int VRF_LANES      = 4;

    localparam int ADDR_B = $clog2(VRF_REG_NUM);
    localparam int ELEM_B = $clog2(VRF_LANES);

    // Largest legal element count, pre-sized to the vl field width.
    localparam logic [ELEM_B:0] VL_MAX = VRF_LANES[ELEM_B:0];

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

    typedef struct packed {
        logic [ADDR_B-1:0] vs1;
        logic [ADDR_B-1:0] vs2;
        logic [ADDR_B-1:0] vs3;
        logic [ADDR_B-1:0] vd;
        logic              use_c;
        logic              use_mask;
        logic [ELEM_B:0]   vl;
    } instr_t;

    // Requests longer than one register's worth of lane elements are
    // truncated to a full register.
    function automatic logic [ELEM_B:0] clip_vl(input logic [ELEM_B:0] vl);
        if (vl > VL_MAX) begin
            return VL_MAX;
        end
        return vl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vrf_lane_seq_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : vrf_lane_seq_cnt
//  Purpose  : Issue/write counter pair for the lane sequencer. ic counts
//             elements handed to the ALU, wc counts results written back.
//             Also provides the occupancy compares the sequencer needs.
//  Ports    : clk_i, resetn_i      - clock, async active-low reset
//             clr_i                - zero both counters (start of EXEC)
//             inc_ic_i / inc_wc_i  - advance issue / write counter
//             vl_i                 - element count of current instruction
//             ic_o / wc_o          - counter values
//             ic_lt_vl_o           - more elements remain to issue
//             pend_o               - results outstanding (wc < ic)
//             wc_last_o            - next write is the final element
//  Revision : 1.0 - initial release
// ============================================================================
module vrf_lane_seq_cnt #(
    parameter int CW = 3
) (
    input  logic          clk_i,
    input  logic          resetn_i,
    input  logic          clr_i,
    input  logic          inc_ic_i,
    input  logic          inc_wc_i,
    input  logic [CW-1:0] vl_i,
    output logic [CW-1:0] ic_o,
    output logic [CW-1:0] wc_o,
    output logic          ic_lt_vl_o,
    output logic          pend_o,
    output logic          wc_last_o
);

    logic [CW-1:0] ic_q, ic_d;
    logic [CW-1:0] wc_q, wc_d;
    logic [CW-1:0] wc_inc;

    assign wc_inc = wc_q + CW'(1);

    always_comb begin
        ic_d = ic_q;
        wc_d = wc_q;
        if (clr_i) begin
            ic_d = '0;
            wc_d = '0;
        end else begin
            if (inc_ic_i) begin
                ic_d = ic_q + CW'(1);
            end
            if (inc_wc_i) begin
                wc_d = wc_inc;
            end
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            ic_q <= '0;
            wc_q <= '0;
        end else begin
            ic_q <= ic_d;
            wc_q <= wc_d;
        end
    end

    assign ic_o       = ic_q;
    assign wc_o       = wc_q;
    assign ic_lt_vl_o = (ic_q < vl_i);
    assign pend_o     = (wc_q < ic_q);
    assign wc_last_o  = (wc_inc == vl_i);

endmodule
`default_nettype wire

// File: rtl/vrf_lane_seq.sv
`default_nettype none
// ============================================================================
//  Module   : vrf_lane_seq
//  Purpose  : Per-lane operand sequencer and writeback controller. Accepts one
//             vector instruction, requests operand fetch from the VRF, streams
//             elements to the lane ALU (valid/ready) and writes in-order ALU
//             results back to vd, honouring the v0 mask.
//  Ports    : clk_i, resetn_i               - clock, async active-low reset
//             issue_* / vs*_i / vd_i / use_* / vl_i - instruction handshake
//             a/b/c/wr_addr_o, is_*_used_o  - latched instruction fields
//             rd_req_o, rd_op_ready_i       - operand fetch request/complete
//             op_valid_o, op_ready_i, rd_elem_cnt_o - ALU element stream
//             res_valid_i, res_data_i       - in-order ALU results
//             mask_i                        - v0 mask bits
//             wr_req_o, wr_en_o, wr_elem_cnt_o, wr_ready_o, wdata_o - VRF write
//             done_o                        - retire pulse
//             err_o                         - sticky unexpected-result flag
//  Revision : 1.0 - initial release
// ============================================================================
module vrf_lane_seq
    import vrf_lane_seq_pkg::*;
#(
    parameter int DATA_WIDTH = VRF_DATA_WIDTH,
    parameter int REG_NUM    = VRF_REG_NUM,
    parameter int LANES      = VRF_LANES
) (
    input  logic                         clk_i,
    input  logic                         resetn_i,
    input  logic                         issue_valid_i,
    output logic                         issue_ready_o,
    input  logic [$clog2(REG_NUM)-1:0]   vs1_i,
    input  logic [$clog2(REG_NUM)-1:0]   vs2_i,
    input  logic [$clog2(REG_NUM)-1:0]   vs3_i,
    input  logic [$clog2(REG_NUM)-1:0]   vd_i,
    input  logic                         use_c_i,
    input  logic                         use_mask_i,
    input  logic [$clog2(LANES):0]       vl_i,
    output logic [$clog2(REG_NUM)-1:0]   a_addr_o,
    output logic [$clog2(REG_NUM)-1:0]   b_addr_o,
    output logic [$clog2(REG_NUM)-1:0]   c_addr_o,
    output logic [$clog2(REG_NUM)-1:0]   wr_addr_o,
    output logic                         rd_req_o,
    output logic                         is_c_used_o,
    output logic                         is_mask_used_o,
    input  logic                         rd_op_ready_i,
    output logic [$clog2(LANES)-1:0]     rd_elem_cnt_o,
    input  logic [DATA_WIDTH-1:0]        mask_i,
    output logic                         wr_req_o,
    output logic                         wr_en_o,
    output logic [$clog2(LANES)-1:0]     wr_elem_cnt_o,
    output logic                         wr_ready_o,
    output logic [DATA_WIDTH-1:0]        wdata_o,
    output logic                         op_valid_o,
    input  logic                         op_ready_i,
    input  logic                         res_valid_i,
    input  logic [DATA_WIDTH-1:0]        res_data_i,
    output logic                         done_o,
    output logic                         err_o
);

    localparam int EW = $clog2(LANES);
    localparam int CW = EW + 1;

    seq_state_e          state_q, state_d;
    instr_t              instr_q, instr_d;
    logic                alive_q;
    logic                wr_req_q;
    logic                wr_en_q;
    logic                wr_ready_q;
    logic [EW-1:0]       wr_elem_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                err_q;

    logic                issue_fire;
    logic                cnt_clr;
    logic                op_fire;
    logic                res_accept;
    logic [CW-1:0]       ic, wc;
    logic                ic_lt_vl, pend, wc_last;
    logic                in_exec;

    // ------------------------------------------------------------------
    // Counter pair
    // ------------------------------------------------------------------
    vrf_lane_seq_cnt #(
        .CW (CW)
    ) u_cnt (
        .clk_i      (clk_i),
        .resetn_i   (resetn_i),
        .clr_i      (cnt_clr),
        .inc_ic_i   (op_fire),
        .inc_wc_i   (res_accept),
        .vl_i       (instr_q.vl),
        .ic_o       (ic),
        .wc_o       (wc),
        .ic_lt_vl_o (ic_lt_vl),
        .pend_o     (pend),
        .wc_last_o  (wc_last)
    );

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    // alive_q keeps issue_ready_o low while reset is held and through the
    // first clock after release.
    assign in_exec     = (state_q == ST_EXEC);
    assign issue_ready_o = (state_q == ST_IDLE) && alive_q;
    assign issue_fire  = issue_valid_i && issue_ready_o;
    assign cnt_clr     = (state_q == ST_WAIT) && rd_op_ready_i;
    assign op_valid_o  = in_exec && ic_lt_vl;
    assign op_fire     = op_valid_o && op_ready_i;
    // A result is only meaningful while an issued element is outstanding.
    assign res_accept  = res_valid_i && in_exec && pend;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (issue_fire) begin
                    instr_d.vs1      = vs1_i;
                    instr_d.vs2      = vs2_i;
                    instr_d.vs3      = vs3_i;
                    instr_d.vd       = vd_i;
                    instr_d.use_c    = use_c_i;
                    instr_d.use_mask = use_mask_i;
                    instr_d.vl       = clip_vl(vl_i);
                    state_d = (clip_vl(vl_i) == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT: begin
                if (rd_op_ready_i) begin
                    state_d = ST_EXEC;
                end
            end
            // Leave EXEC only once the final write slot is on the port.
            ST_EXEC: begin
                if (wr_ready_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and write-port registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q    <= ST_IDLE;
            instr_q    <= '0;
            alive_q    <= 1'b0;
            wr_req_q   <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_ready_q <= 1'b0;
            wr_elem_q  <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            alive_q    <= 1'b1;
            wr_req_q   <= cnt_clr;
            // Masked-off elements still occupy a slot, just without strobe.
            wr_en_q    <= res_accept &&
                          (!instr_q.use_mask || mask_i[wc[EW-1:0]]);
            wr_ready_q <= res_accept && wc_last;
            if (res_accept) begin
                wr_elem_q <= wc[EW-1:0];
                wdata_q   <= res_data_i;
            end
            if (res_valid_i && !res_accept) begin
                err_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rd_req_o       = (state_q == ST_FETCH);
    assign done_o         = (state_q == ST_DONE);
    assign rd_elem_cnt_o  = ic[EW-1:0];
    assign a_addr_o       = instr_q.vs1;
    assign b_addr_o       = instr_q.vs2;
    assign c_addr_o       = instr_q.vs3;
    assign wr_addr_o      = instr_q.vd;
    assign is_c_used_o    = instr_q.use_c;
    assign is_mask_used_o = instr_q.use_mask;
    assign wr_req_o       = wr_req_q;
    assign wr_en_o        = wr_en_q;
    assign wr_ready_o     = wr_ready_q;
    assign wr_elem_cnt_o  = wr_elem_q;
    assign wdata_o        = wdata_q;
    assign err_o          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_vrf_lane_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_vrf_lane_seq
//  Purpose  : Self-checking bench for vrf_lane_seq. Drives instructions and an
//             ALU/VRF environment, predicts each cycle's protocol outputs from
//             the element-level behaviour (queue of issued elements and their
//             results) and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vrf_lane_seq;

    logic        clk_i = 1'b0;
    logic        resetn_i;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic [4:0]  vs1_i, vs2_i, vs3_i, vd_i;
    logic        use_c_i, use_mask_i;
    logic [2:0]  vl_i;
    logic [4:0]  a_addr_o, b_addr_o, c_addr_o, wr_addr_o;
    logic        rd_req_o, is_c_used_o, is_mask_used_o;
    logic        rd_op_ready_i;
    logic [1:0]  rd_elem_cnt_o;
    logic [31:0] mask_i;
    logic        wr_req_o, wr_en_o, wr_ready_o;
    logic [1:0]  wr_elem_cnt_o;
    logic [31:0] wdata_o;
    logic        op_valid_o, op_ready_i;
    logic        res_valid_i;
    logic [31:0] res_data_i;
    logic        done_o, err_o;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic err_exp = 1'b0;

    always #5 clk_i = ~clk_i;

    vrf_lane_seq dut (
        .clk_i          (clk_i),
        .resetn_i       (resetn_i),
        .issue_valid_i  (issue_valid_i),
        .issue_ready_o  (issue_ready_o),
        .vs1_i          (vs1_i),
        .vs2_i          (vs2_i),
        .vs3_i          (vs3_i),
        .vd_i           (vd_i),
        .use_c_i        (use_c_i),
        .use_mask_i     (use_mask_i),
        .vl_i           (vl_i),
        .a_addr_o       (a_addr_o),
        .b_addr_o       (b_addr_o),
        .c_addr_o       (c_addr_o),
        .wr_addr_o      (wr_addr_o),
        .rd_req_o       (rd_req_o),
        .is_c_used_o    (is_c_used_o),
        .is_mask_used_o (is_mask_used_o),
        .rd_op_ready_i  (rd_op_ready_i),
        .rd_elem_cnt_o  (rd_elem_cnt_o),
        .mask_i         (mask_i),
        .wr_req_o       (wr_req_o),
        .wr_en_o        (wr_en_o),
        .wr_elem_cnt_o  (wr_elem_cnt_o),
        .wr_ready_o     (wr_ready_o),
        .wdata_o        (wdata_o),
        .op_valid_o     (op_valid_o),
        .op_ready_i     (op_ready_i),
        .res_valid_i    (res_valid_i),
        .res_data_i     (res_data_i),
        .done_o         (done_o),
        .err_o          (err_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        issue_valid_i = 1'b0;
        vs1_i = '0; vs2_i = '0; vs3_i = '0; vd_i = '0;
        use_c_i = 1'b0; use_mask_i = 1'b0; vl_i = '0;
        rd_op_ready_i = 1'b0;
        op_ready_i = 1'b0;
        res_valid_i = 1'b0;
        res_data_i = '0;
        mask_i = '0;
    endtask

    // Every output folded into two vectors for the reset checks.
    function automatic logic [63:0] outs_ctl();
        return {38'h0, issue_ready_o, a_addr_o, b_addr_o, c_addr_o, wr_addr_o,
                rd_req_o, is_c_used_o, is_mask_used_o, rd_elem_cnt_o};
    endfunction
    function automatic logic [63:0] outs_wr();
        return {24'h0, wr_req_o, wr_en_o, wr_elem_cnt_o, wr_ready_o, wdata_o,
                op_valid_o, done_o, err_o};
    endfunction

    // Runs one instruction. Cycle t counts negedges after the issue edge.
    // fd: cycles after rd_req before the VRF reports operands ready.
    // rmode: 0 ALU always ready, 1 toggling 1,0,1,0, 2 random.
    // rdel: cycles from element acceptance to its result.
    // abort_n: if >0, reset is asserted after that many write slots.
    task automatic run_instr(input logic [4:0] vs1, input logic [4:0] vs2,
                             input logic [4:0] vs3, input logic [4:0] vd,
                             input logic uc, input logic um, input logic [2:0] vl,
                             input logic [3:0] msk, input int fd, input int rmode,
                             input int rdel, input int abort_n);
        int          vle, t, w, tog;
        int          exp_rd_at, exp_wr_at, exp_done_at, ordy_at;
        int          n_iss, n_res, n_slots;
        logic [31:0] resq[$];
        int          dueq[$];
        logic        slot_exp, rdy, done_seen;
        int          slot_idx;
        logic [31:0] slot_data;

        vle = (vl > 3'd4) ? 4 : int'(vl);
        w = 0;
        while (!issue_ready_o && w < 50) begin
            @(negedge clk_i);
            w++;
        end
        check_eq("issue_ready_wait", issue_ready_o, 1);

        issue_valid_i = 1'b1;
        vs1_i = vs1; vs2_i = vs2; vs3_i = vs3; vd_i = vd;
        use_c_i = uc; use_mask_i = um; vl_i = vl;
        mask_i = {$urandom_range(0, 32'h0fff_ffff), msk};

        exp_rd_at   = (vle == 0) ? -1 : 1;
        ordy_at     = (vle == 0) ? -1 : 1 + fd;
        exp_wr_at   = (vle == 0) ? -1 : 2 + fd;
        exp_done_at = (vle == 0) ? 1 : -1;
        n_iss = 0; n_res = 0; n_slots = 0; tog = 0;
        slot_exp = 1'b0; slot_idx = 0; slot_data = '0; done_seen = 1'b0;
        t = 0;

        while (!done_seen && t < 200) begin
            @(posedge clk_i);
            @(negedge clk_i);
            t++;
            issue_valid_i = 1'b0;

            // ---- sample and compare ----
            check_eq("rd_req", rd_req_o, (t == exp_rd_at));
            check_eq("wr_req", wr_req_o, (t == exp_wr_at));
            check_eq("done", done_o, (t == exp_done_at));
            check_eq("op_valid", op_valid_o, (vle > 0 && t >= exp_wr_at && n_iss < vle));
            if (op_valid_o) begin
                check_eq("rd_elem_cnt", rd_elem_cnt_o, n_iss);
            end
            check_eq("wr_en", wr_en_o, slot_exp && (!um || msk[slot_idx]));
            check_eq("wr_ready", wr_ready_o, slot_exp && (slot_idx == vle - 1));
            if (slot_exp) begin
                check_eq("wr_elem_cnt", wr_elem_cnt_o, slot_idx);
                check_eq("wdata", wdata_o, slot_data);
                n_slots++;
                if (slot_idx == vle - 1) begin
                    exp_done_at = t + 1;
                end
            end
            if (vle > 0) begin
                check_eq("fields", {a_addr_o, b_addr_o, c_addr_o, wr_addr_o, is_c_used_o, is_mask_used_o},
                         {vs1, vs2, vs3, vd, uc, um});
            end
            check_eq("err", err_o, err_exp);
            if (done_o) begin
                done_seen = 1'b1;
            end

            if (abort_n > 0 && n_slots == abort_n) begin
                #2;
                resetn_i = 1'b0;
                #1;
                check_eq("midreset_ctl", outs_ctl(), 0);
                check_eq("midreset_wr", outs_wr(), 0);
                drive_idle();
                repeat (2) @(negedge clk_i);
                check_eq("held_reset_ctl", outs_ctl(), 0);
                resetn_i = 1'b1;
                #1;
                check_eq("ready_after_release", issue_ready_o, 0);
                @(negedge clk_i);
                check_eq("ready_first_clock", issue_ready_o, 1);
                err_exp = 1'b0;
                check_eq("err_cleared", err_o, 0);
                return;
            end

            // ---- drive next cycle ----
            rd_op_ready_i = (vle > 0 && t == ordy_at);
            if (vle > 0 && t >= exp_wr_at) begin
                case (rmode)
                    0:       rdy = 1'b1;
                    1:       rdy = (tog % 2 == 0);
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                tog++;
            end else begin
                rdy = 1'($urandom_range(0, 1));
            end
            op_ready_i = rdy;
            if (op_valid_o && rdy) begin
                resq.push_back($urandom);
                dueq.push_back(t + rdel);
                n_iss++;
            end
            slot_exp = 1'b0;
            res_valid_i = 1'b0;
            res_data_i = $urandom;
            if (dueq.size() > 0 && dueq[0] <= t) begin
                res_valid_i = 1'b1;
                res_data_i = resq.pop_front();
                void'(dueq.pop_front());
                slot_exp = 1'b1;
                slot_idx = n_res;
                slot_data = res_data_i;
                n_res++;
            end
        end
        check_eq("completed", done_seen, 1);
        check_eq("slot_count", n_slots, vle);
        drive_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetn_i = 1'b0;
        drive_idle();
        repeat (3) @(negedge clk_i);
        check_eq("reset_ctl", outs_ctl(), 0);
        check_eq("reset_wr", outs_wr(), 0);
        resetn_i = 1'b1;
        #1;
        check_eq("ready_held_low", issue_ready_o, 0);
        @(negedge clk_i);
        check_eq("ready_after_reset", issue_ready_o, 1);

        // Basic vl=4 stream, ALU always ready, one-cycle result latency.
        run_instr(5'd3, 5'd9, 5'd0, 5'd12, 1'b0, 1'b0, 3'd4, 4'h0, 1, 0, 1, 0);
        // Third operand, 4-cycle VRF fetch delay.
        run_instr(5'd1, 5'd2, 5'd7, 5'd4, 1'b1, 1'b0, 3'd4, 4'h0, 4, 0, 1, 0);
        // Masked writeback: only elements 0 and 2 strobe.
        run_instr(5'd5, 5'd6, 5'd8, 5'd10, 1'b0, 1'b1, 3'd4, 4'b0101, 1, 0, 1, 0);
        // Toggling ALU ready, results delayed 3 cycles.
        run_instr(5'd11, 5'd13, 5'd17, 5'd19, 1'b0, 1'b0, 3'd4, 4'h0, 2, 1, 3, 0);
        // Requested length above lane count clips to 4.
        run_instr(5'd21, 5'd22, 5'd23, 5'd24, 1'b1, 1'b1, 3'd7, 4'b1010, 1, 2, 2, 0);

        for (int i = 0; i < 20; i++) begin
            run_instr(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                      5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                      $urandom_range(1, 5), $urandom_range(0, 2),
                      $urandom_range(1, 4), 0);
        end

        // Zero-length instruction: retire next cycle, no VRF traffic.
        run_instr(5'd2, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0, 3'd0, 4'h0, 1, 0, 1, 0);

        // Spurious result while idle is flagged and sticky.
        @(negedge clk_i);
        res_valid_i = 1'b1;
        res_data_i = 32'hdead_beef;
        @(negedge clk_i);
        res_valid_i = 1'b0;
        check_eq("spurious_err", err_o, 1);
        check_eq("spurious_no_write", wr_en_o, 0);
        repeat (3) @(negedge clk_i);
        check_eq("err_sticky", err_o, 1);
        err_exp = 1'b1;
        run_instr(5'd8, 5'd9, 5'd10, 5'd11, 1'b0, 1'b0, 3'd1, 4'h0, 1, 0, 1, 0);

        // Reset mid-EXEC after two writes, then a clean vl=2 instruction.
        run_instr(5'd14, 5'd15, 5'd16, 5'd18, 1'b0, 1'b0, 3'd4, 4'h0, 1, 0, 2, 2);
        run_instr(5'd25, 5'd26, 5'd27, 5'd28, 1'b0, 1'b0, 3'd2, 4'h0, 1, 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vrf_lane_seq.md
# vrf_lane_seq

Per-lane operand sequencer and writeback controller: the requesting side of the lane vector register file's read and write port protocol. Accepts one vector instruction at a time and asks the register file to fetch operands A, B and optionally C. It then streams elements to the lane ALU under a valid/ready handshake and writes in-order ALU results back to the destination register, honouring the v0 mask. Sits between the lane issue stage and the VRF bank/ALU pair.

## Interface
- DATA_WIDTH, 32, element width
- REG_NUM, 32, architectural vector registers; ADDR_B = $clog2(REG_NUM)
- LANES, 4, elements per register per lane; ELEM_B = $clog2(LANES)

Ports:
- clk_i  in  1  clock
- resetn_i  in  1  asynchronous, active-low reset
- issue_valid_i  in  1  instruction offered
- issue_ready_o  out  1  sequencer idle, accepts instruction
- vs1_i, vs2_i, vs3_i, vd_i  in  ADDR_B each  source A/B/C and destination register
- use_c_i  in  1  third operand required
- use_mask_i  in  1  apply v0 mask to writeback
- vl_i  in  ELEM_B+1  element count, 0..LANES
- a_addr_o, b_addr_o, c_addr_o, wr_addr_o  out  ADDR_B  registered copies of vs1/vs2/vs3/vd
- rd_req_o  out  1  operand fetch request, one-cycle pulse
- is_c_used_o, is_mask_used_o  out  1  registered use_c/use_mask
- rd_op_ready_i  in  1  VRF operand fetch complete
- rd_elem_cnt_o  out  ELEM_B  element index presented to ALU
- mask_i  in  DATA_WIDTH  mask read data; bit i gates element i
- wr_req_o  out  1  opens VRF write window, one-cycle pulse
- wr_en_o  out  1  write strobe for wr_elem_cnt_o
- wr_elem_cnt_o  out  ELEM_B  element index being written
- wr_ready_o  out  1  closes write window, coincides with last write slot
- wdata_o  out  DATA_WIDTH  write data
- op_valid_o  out  1  operands at rd_elem_cnt_o valid for ALU
- op_ready_i  in  1  ALU accepts element
- res_valid_i  in  1  ALU result valid, in order
- res_data_i  in  DATA_WIDTH  ALU result
- done_o  out  1  instruction retired, one-cycle pulse
- err_o  out  1  sticky: result received with none outstanding

## Operation
- States: IDLE, FETCH, WAIT, EXEC, DONE.
- IDLE: issue_ready_o=1. A handshake registers all fields. Clip vl to LANES. vl=0 goes to DONE; otherwise FETCH.
- FETCH: rd_req_o=1 for exactly one cycle, then WAIT.
- WAIT: hold until rd_op_ready_i=1. Then pulse wr_req_o, clear issue counter `ic` and write counter `wc`, enter EXEC.
- EXEC, issue side: op_valid_o=1 while ic<vl, with rd_elem_cnt_o=ic. Each op_valid_o&&op_ready_i increments ic.
- EXEC, write side: each res_valid_i with wc<ic registers res_data_i into wdata_o, drives wr_elem_cnt_o=wc, increments wc.
  - wr_en_o=1 unless use_mask and mask_i[wc]=0. Masked elements consume the slot with wr_en_o=0.
  - wr_ready_o=1 in the slot where wc reaches vl; the next state is DONE.
- res_valid_i with wc==ic is ignored and sets err_o. err_o clears only on reset.
- DONE: done_o=1 for one cycle, then IDLE.
- Issue and result in the same cycle are both honoured. ic-wc never exceeds LANES.
- Reset, including mid-instruction: state IDLE and every output 0. issue_ready_o rises on the first clock after release. Counters and err_o clear. No partial write is completed.

## Timing
- issue handshake at edge N: rd_req_o high in cycle N+1.
- rd_op_ready_i high at edge M: wr_req_o and the first op_valid_o in cycle M+1.
- With op_ready_i held high, one element per cycle: vl elements occupy vl cycles.
- Write strobe and wdata_o are registered: one cycle after the accepting res_valid_i edge, high for one cycle.
- done_o follows the cycle carrying wr_ready_o. Minimum instruction, vl=1 with the ALU result the cycle after issue: issue, FETCH, WAIT(VRF), EXEC(2), DONE.
- vl=0: done_o in cycle N+1, no VRF traffic.
- Registered address/flag outputs are stable from FETCH until DONE.

## Structure
- Shared vector package holds the state enum, ADDR_B/ELEM_B derivations, and an instruction-field struct (vs1, vs2, vs3, vd, use_c, use_mask, vl).
- Single module. A small counter-pair sub-module `vrf_lane_seq_cnt` (ic/wc, occupancy compare) is acceptable; no other hierarchy.

## Test plan
- vl=4, no C, no mask, ALU ready always, result 1 cycle later:
  - rd_req_o pulse once, a_addr_o/b_addr_o = vs1/vs2.
  - Four writes with wr_elem_cnt_o 0,1,2,3 and wdata_o = results.
  - wr_ready_o on element 3; one done_o.
- use_c_i=1, vs3=7: is_c_used_o=1 and c_addr_o=7 through the instruction. EXEC starts only after rd_op_ready_i, tested with a 4-cycle delay.
- use_mask_i=1, mask_i=4'b0101, vl=4: wr_en_o high for elements 0 and 2 only. All four slots occur; wr_ready_o on slot 3.
- op_ready_i toggled 1,0,1,0 with results delayed 3 cycles: rd_elem_cnt_o holds while stalled. Writes stay in order 0..3, no drop or duplicate.
- vl=0: done_o the next cycle, rd_req_o/wr_req_o never asserted. A spurious res_valid_i in IDLE sets err_o=1, which stays 1.
- resetn_i asserted mid-EXEC after 2 writes: all outputs 0 immediately. After release, issue_ready_o=1 and a new vl=2 instruction completes cleanly.
